// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial pins plus frame handshake for the I2S receiver.
// master drives the pins and ready; slave is the receiver.
interface i2s_rx_if #(
  parameter int WIDTH = 24
);
  logic             lrclk;
  logic             sdata;
  logic             ready;
  logic [WIDTH-1:0] left_data;
  logic [WIDTH-1:0] right_data;
  logic             valid;
  logic             overrun;
  logic             locked;

  modport master (
    output lrclk, sdata, ready,
    input  left_data, right_data,
    input  valid, overrun, locked
  );

  modport slave (
    input  lrclk, sdata, ready,
    output left_data, right_data,
    output valid, overrun, locked
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: I2S serial-to-parallel receiver clocked by sclk.
// Define I2S_RX_LJ_EN for left-justified format (no one-bit delay).
module i2s_rx #(
  parameter int WIDTH = 24,
  parameter int SLOT  = 32
) (
  input logic  sclk,
  input logic  Reset,
  i2s_rx_if.slave bus
);

  localparam int NW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(SLOT + 1);

  typedef enum logic [1:0] {
    SYNC,
    SKIP,
    CAPTURE,
    WAIT
  } state_t;

  state_t           state;
  logic             lr_q;
  logic             ch;
  logic             have_left;
  logic [NW-1:0]    n;
  logic [CW-1:0]    slot_cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] left_hold;
  logic [WIDTH-1:0] left_q;
  logic [WIDTH-1:0] right_q;
  logic             valid_q;
  logic             overrun_q;
  logic             locked_q;

  logic             edge_det;
  logic             fall;
  logic             timeout;
  logic             in_cap;
  logic             full;
  logic             commit;
  logic [NW-1:0]    n_cur;
  logic [WIDTH-1:0] sr_cur;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] word;

  assign bus.left_data  = left_q;
  assign bus.right_data = right_q;
  assign bus.valid      = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.locked     = locked_q;

  // Slot edges, lock timeout and the word being committed this cycle
  always_comb begin
    edge_det = bus.lrclk != lr_q;
    fall     = edge_det && !bus.lrclk;
    timeout  = (state != SYNC) && !edge_det
               && (slot_cnt == CW'(SLOT));
    in_cap   = (state == SKIP) || (state == CAPTURE);
    n_cur    = (state == SKIP) ? '0 : n;
    sr_cur   = (state == SKIP) ? '0 : sr;
    sr_nxt   = (sr_cur << 1) | WIDTH'(bus.sdata);
    full     = n_cur == NW'(WIDTH - 1);
    commit   = in_cap && (edge_det || full);
`ifdef I2S_RX_LJ_EN
    // Edge bit opens the new slot, so a short word ends before it
    if (edge_det)
      word = sr_cur << (NW'(WIDTH) - n_cur);
    else
      word = sr_nxt;
`else
    // Edge bit is the last bit of the closing slot
    word = sr_nxt << (NW'(WIDTH - 1) - n_cur);
`endif
  end

  // Frame assembly, handshake, FSM and lock supervision
  always_ff @(posedge sclk) begin
    lr_q <= bus.lrclk;
    if (Reset) begin
      state     <= SYNC;
      ch        <= 1'b0;
      have_left <= 1'b0;
      n         <= '0;
      slot_cnt  <= '0;
      sr        <= '0;
      left_hold <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      if (edge_det)
        slot_cnt <= '0;
      else if (slot_cnt != CW'(SLOT))
        slot_cnt <= slot_cnt + CW'(1);

      if (bus.ready && valid_q)
        valid_q <= 1'b0;

      if (commit) begin
        if (!ch) begin
          left_hold <= word;
          have_left <= 1'b1;
        end else if (have_left) begin
          left_q    <= left_hold;
          right_q   <= word;
          valid_q   <= 1'b1;
          have_left <= 1'b0;
          if (valid_q && !bus.ready)
            overrun_q <= 1'b1;
        end
      end

      unique case (state)
        SYNC: begin
          if (fall) begin
            ch <= 1'b0;
`ifdef I2S_RX_LJ_EN
            state <= CAPTURE;
            sr    <= WIDTH'(bus.sdata);
            n     <= NW'(1);
`else
            state <= SKIP;
`endif
          end
        end
        SKIP, CAPTURE: begin
          if (edge_det) begin
            ch <= bus.lrclk;
`ifdef I2S_RX_LJ_EN
            state <= CAPTURE;
            sr    <= WIDTH'(bus.sdata);
            n     <= NW'(1);
`else
            state <= SKIP;
`endif
          end else if (full) begin
            state <= WAIT;
          end else begin
            state <= CAPTURE;
            sr    <= sr_nxt;
            n     <= n_cur + NW'(1);
          end
        end
        WAIT: begin
          if (edge_det) begin
            ch <= bus.lrclk;
`ifdef I2S_RX_LJ_EN
            state <= CAPTURE;
            sr    <= WIDTH'(bus.sdata);
            n     <= NW'(1);
`else
            state <= SKIP;
`endif
          end
        end
        default: state <= SYNC;
      endcase

      if (timeout) begin
        state     <= SYNC;
        have_left <= 1'b0;
      end

      locked_q <= !timeout && ((state != SYNC) || fall);
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed I2S streams with a frame scoreboard.
// Covers timing, overrun, short slot, lock loss and reset.
module tb_i2s_rx;

  localparam int W = 24;
  localparam int S = 32;
`ifdef I2S_RX_LJ_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } frame_t;

  logic sclk;
  logic Reset;
  int   checks;
  int   failures;
  int   cyc;
  int   vcnt;
  int   rise_cyc;
  int   lock_fall;
  logic vd;
  logic ld;
  logic carry;
  int   last_edge;
  frame_t sb[$];

  i2s_rx_if #(.WIDTH(W)) bus();

  i2s_rx #(
    .WIDTH(W),
    .SLOT (S)
  ) dut (
    .sclk (sclk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    vcnt      = 0;
    rise_cyc  = 0;
    lock_fall = 0;
    vd        = 1'b0;
    ld        = 1'b0;
  end

  always @(negedge sclk) begin
    if (bus.valid) vcnt = vcnt + 1;
    if (bus.valid && !vd) rise_cyc = cyc;
    if (ld && !bus.locked) lock_fall = cyc;
    vd = bus.valid;
    ld = bus.locked;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag);
    frame_t e;
    if (sb.size() == 0) begin
      checks   = checks + 1;
      failures = failures + 1;
      $error("FAIL %s observed=empty expected=frame", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_left"}, 32'(bus.left_data), 32'(e.l));
      chk({tag, "_right"}, 32'(bus.right_data), 32'(e.r));
    end
  endtask

  task automatic drive(input logic lr, input logic sd);
    bus.lrclk = lr;
    bus.sdata = sd;
    @(negedge sclk);
  endtask

  function automatic logic bit_of(input logic [W-1:0] w,
                                  input int i);
    if (i < W) return w[W-1-i];
    return 1'b0;
  endfunction

  task automatic send_slot(input logic c,
                           input logic [W-1:0] w,
                           input int len);
    logic sd;
    last_edge = cyc + 1;
    for (int j = 0; j < len; j++) begin
      if (LJ) sd = bit_of(w, j);
      else if (j == 0) sd = carry;
      else sd = bit_of(w, j - 1);
      drive(c, sd);
    end
    carry = bit_of(w, len - 1);
  endtask

  task automatic send_frame(input logic [W-1:0] l,
                            input logic [W-1:0] r);
    frame_t f;
    f.l = l;
    f.r = r;
    sb.push_back(f);
    send_slot(1'b0, l, S);
    send_slot(1'b1, r, S);
  endtask

  initial begin
    int k;
    int v0;
    frame_t f;
    checks    = 0;
    failures  = 0;
    carry     = 1'b0;
    last_edge = 0;
    Reset     = 1'b1;
    bus.ready = 1'b1;
    @(negedge sclk);
    repeat (5) drive(1'b1, 1'b0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
    chk("rst_left", 32'(bus.left_data), 32'd0);
    chk("rst_right", 32'(bus.right_data), 32'd0);
    Reset = 1'b0;
    repeat (4) drive(1'b1, 1'b0);
    chk("sync_locked", 32'(bus.locked), 32'd0);

    // Basic frame with ready held high
    v0 = vcnt;
    send_slot(1'b0, 24'hA5A5A5, S);
    k = last_edge;
    send_slot(1'b1, 24'h3C3C3C, S);
    f.l = 24'hA5A5A5;
    f.r = 24'h3C3C3C;
    sb.push_back(f);
    chk("valid_time", 32'(rise_cyc),
        32'(LJ ? k + S + W - 1 : k + S + W));
    chk("valid_pulse", 32'(vcnt - v0), 32'd1);
    chk_frame("basic");
    chk("basic_overrun", 32'(bus.overrun), 32'd0);
    chk("basic_locked", 32'(bus.locked), 32'd1);

    // Two frames without acceptance
    bus.ready = 1'b0;
    send_slot(1'b0, 24'h123456, S);
    send_slot(1'b1, 24'h654321, S);
    chk("ovr_valid1", 32'(bus.valid), 32'd1);
    chk("ovr_flag1", 32'(bus.overrun), 32'd0);
    send_frame(24'hABCDEF, 24'hFEDCBA);
    chk("ovr_flag2", 32'(bus.overrun), 32'd1);
    chk_frame("ovr_newest");
    bus.ready = 1'b1;
    send_frame(24'h111111, 24'h222222);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    chk_frame("ovr_after");

    // Short right slot of 16 bits
    send_slot(1'b0, 24'h0F0F0F, S);
    send_slot(1'b1, 24'hFFFFFF, 16);
    f.l = 24'h0F0F0F;
    f.r = 24'hFFFF00;
    sb.push_back(f);
    send_slot(1'b0, 24'h5A5A5A, S);
    chk_frame("short");
    send_slot(1'b1, 24'hC3C3C3, S);
    f.l = 24'h5A5A5A;
    f.r = 24'hC3C3C3;
    sb.push_back(f);
    chk_frame("post_short");

    // Right slot stretched to 72 cycles loses lock
    send_slot(1'b0, 24'h246813, S);
    send_slot(1'b1, 24'h135792, S + 40);
    k = last_edge;
    f.l = 24'h246813;
    f.r = 24'h135792;
    sb.push_back(f);
    chk("lock_fall", 32'(lock_fall), 32'(k + S + 1));
    chk("unlocked", 32'(bus.locked), 32'd0);
    chk_frame("pre_loss");
    send_frame(24'h0BADC0, 24'hDEFACE);
    chk("relocked", 32'(bus.locked), 32'd1);
    chk_frame("relock");

    // Reset in the middle of a right slot
    send_slot(1'b0, 24'h999999, S);
    repeat (10) drive(1'b1, 1'b1);
    Reset = 1'b1;
    drive(1'b1, 1'b0);
    Reset = 1'b0;
    chk("mid_valid", 32'(bus.valid), 32'd0);
    chk("mid_overrun", 32'(bus.overrun), 32'd0);
    chk("mid_locked", 32'(bus.locked), 32'd0);
    chk("mid_left", 32'(bus.left_data), 32'd0);
    chk("mid_right", 32'(bus.right_data), 32'd0);
    carry = 1'b0;
    v0 = vcnt;
    send_slot(1'b1, 24'h777777, S);
    chk("orphan_right", 32'(vcnt - v0), 32'd0);
    send_frame(24'h13579B, 24'h2468AC);
    chk_frame("after_rst");
    chk("after_rst_pulse", 32'(vcnt - v0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
